// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: frame-rate ball, paddle and score sequencer.
// Define PONG_AI_EN to make player 2 track the ball automatically.
module pong_game_ctrl #(
  parameter int H_ACTIVE     = 640,
  parameter int V_ACTIVE     = 480,
  parameter int PADDLE_H     = 48,
  parameter int PADDLE_X1    = 16,
  parameter int PADDLE_X2    = 616,
  parameter int BALL_SIZE    = 8,
  parameter int BALL_SPEED   = 2,
  parameter int PADDLE_SPEED = 4,
  parameter int WIN_SCORE    = 7,
  parameter int SERVE_FRAMES = 60
) (
  input  logic       CLOCK_50,
  input  logic       reset_n,
  input  logic       frame_tick,
  input  logic       serve,
  input  logic       p1_up,
  input  logic       p1_dn,
  input  logic       p2_up,
  input  logic       p2_dn,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic [9:0] p1_y,
  output logic [9:0] p2_y,
  output logic [3:0] score1,
  output logic [3:0] score2,
  output logic [2:0] state,
  output logic [1:0] winner
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SERVE = 3'd1;
  localparam logic [2:0] S_PLAY  = 3'd2;
  localparam logic [2:0] S_POINT = 3'd3;
  localparam logic [2:0] S_OVER  = 3'd4;

  localparam logic [10:0] HA   = 11'(H_ACTIVE);
  localparam logic [10:0] VA   = 11'(V_ACTIVE);
  localparam logic [10:0] PH   = 11'(PADDLE_H);
  localparam logic [10:0] X1E  = 11'(PADDLE_X1 + 8);
  localparam logic [10:0] X2   = 11'(PADDLE_X2);
  localparam logic [10:0] BS   = 11'(BALL_SIZE);
  localparam logic [10:0] SP   = 11'(BALL_SPEED);
  localparam logic [10:0] PS   = 11'(PADDLE_SPEED);
  localparam logic [10:0] PMAX = 11'(V_ACTIVE - PADDLE_H);
  localparam logic [10:0] CX   = 11'((H_ACTIVE - BALL_SIZE) / 2);
  localparam logic [10:0] CY   = 11'((V_ACTIVE - BALL_SIZE) / 2);
  localparam logic [10:0] PC   = 11'((V_ACTIVE - PADDLE_H) / 2);

  localparam int CW = $clog2(SERVE_FRAMES + 1);
  localparam logic [CW-1:0] SF = CW'(SERVE_FRAMES);
  localparam logic [CW-1:0] C1 = CW'(1);
  localparam logic [3:0]    WS = 4'(WIN_SCORE);

  logic          dir_x;
  logic          dir_y;
  logic          scorer;
  logic [CW-1:0] cnt;

  logic [10:0] bx, by, p1e, p2e;
  logic [10:0] nbx, nby, np1, np2;
  logic        ndx, ndy;
  logic        ov1, ov2;
  logic        miss, miss_p2;
  logic        p2_up_c, p2_dn_c;
  logic [3:0]  s_new;

  function automatic logic [10:0] pad_move(
    input logic [10:0] y,
    input logic        up,
    input logic        dn
  );
    pad_move = y;
    if (up && !dn)
      pad_move = (y < PS) ? 11'd0 : y - PS;
    else if (dn && !up)
      pad_move = (y + PS > PMAX) ? PMAX : y + PS;
  endfunction

  assign bx  = {1'b0, ball_x};
  assign by  = {1'b0, ball_y};
  assign p1e = {1'b0, p1_y};
  assign p2e = {1'b0, p2_y};

`ifdef PONG_AI_EN
  logic [10:0] pad_c, ball_c;

  // Dead band of +/-4 keeps the paddle from dithering around the ball.
  always_comb begin
    pad_c   = p2e + 11'(PADDLE_H / 2);
    ball_c  = by + 11'(BALL_SIZE / 2);
    p2_up_c = pad_c > ball_c + 11'd4;
    p2_dn_c = pad_c + 11'd4 < ball_c;
  end
`else
  assign p2_up_c = p2_up;
  assign p2_dn_c = p2_dn;
`endif

  assign np1 = pad_move(p1e, p1_up, p1_dn);
  assign np2 = pad_move(p2e, p2_up_c, p2_dn_c);

  assign s_new = (scorer ? score2 : score1) + 4'd1;

  // Collisions use the paddle positions from before this frame's move.
  always_comb begin
    ov1     = (by + BS > p1e) && (by < p1e + PH);
    ov2     = (by + BS > p2e) && (by < p2e + PH);
    nbx     = bx;
    ndx     = dir_x;
    miss    = 1'b0;
    miss_p2 = 1'b0;
    if (!dir_x) begin
      if (bx >= X1E && bx - SP < X1E && ov1) begin
        nbx = X1E;
        ndx = 1'b1;
      end else if (bx < SP) begin
        miss    = 1'b1;
        miss_p2 = 1'b1;
      end else begin
        nbx = bx - SP;
      end
    end else begin
      if (bx + BS <= X2 && bx + BS + SP > X2 && ov2) begin
        nbx = X2 - BS;
        ndx = 1'b0;
      end else if (bx + BS + SP > HA) begin
        miss = 1'b1;
      end else begin
        nbx = bx + SP;
      end
    end
  end

  always_comb begin
    nby = by;
    ndy = dir_y;
    if (!dir_y) begin
      if (by < SP) begin
        nby = 11'd0;
        ndy = 1'b1;
      end else begin
        nby = by - SP;
      end
    end else begin
      if (by + BS + SP > VA) begin
        nby = VA - BS;
        ndy = 1'b0;
      end else begin
        nby = by + SP;
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      ball_x <= CX[9:0];
      ball_y <= CY[9:0];
      p1_y   <= PC[9:0];
      p2_y   <= PC[9:0];
      score1 <= 4'd0;
      score2 <= 4'd0;
      state  <= S_IDLE;
      winner <= 2'b00;
      dir_x  <= 1'b1;
      dir_y  <= 1'b1;
      scorer <= 1'b0;
      cnt    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (serve) begin
            state <= S_SERVE;
            cnt   <= SF;
          end
        end
        S_SERVE: begin
          if (frame_tick) begin
            cnt  <= cnt - C1;
            p1_y <= np1[9:0];
            p2_y <= np2[9:0];
            if (cnt <= C1)
              state <= S_PLAY;
          end
        end
        S_PLAY: begin
          if (frame_tick) begin
            p1_y   <= np1[9:0];
            p2_y   <= np2[9:0];
            ball_x <= nbx[9:0];
            ball_y <= nby[9:0];
            dir_x  <= ndx;
            dir_y  <= ndy;
            if (miss) begin
              state  <= S_POINT;
              scorer <= miss_p2;
            end
          end
        end
        S_POINT: begin
          if (scorer)
            score2 <= s_new;
          else
            score1 <= s_new;
          if (s_new == WS) begin
            state  <= S_OVER;
            winner <= scorer ? 2'b10 : 2'b01;
          end else begin
            // Serve toward the player who just conceded.
            state  <= S_SERVE;
            ball_x <= CX[9:0];
            ball_y <= CY[9:0];
            dir_x  <= ~scorer;
            dir_y  <= 1'b1;
            cnt    <= SF;
          end
        end
        S_OVER: begin
          if (serve) begin
            state  <= S_SERVE;
            score1 <= 4'd0;
            score2 <= 4'd0;
            winner <= 2'b00;
            ball_x <= CX[9:0];
            ball_y <= CY[9:0];
            p1_y   <= PC[9:0];
            p2_y   <= PC[9:0];
            dir_x  <= 1'b1;
            dir_y  <= 1'b1;
            cnt    <= SF;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/pong_game_ctrl.md
Name: pong_game_ctrl

Overview:
- Frame-rate game sequencer for socially-distanced pong.
- Owns ball, paddle and score state, advancing it once per video frame on a vertical-blank pulse from the VGA timing block.
- Exposes registered object coordinates that the pixel painter compares against row/col.
- Runs entirely in the CLOCK_50 domain.

Parameters:
- H_ACTIVE, 640, visible columns
- V_ACTIVE, 480, visible rows
- PADDLE_H, 48, paddle height in pixels
- PADDLE_X1, 16, left paddle left edge; paddle spans PADDLE_X1..PADDLE_X1+7
- PADDLE_X2, 616, right paddle left edge; paddle spans PADDLE_X2..PADDLE_X2+7
- BALL_SIZE, 8, ball edge length
- BALL_SPEED, 2, ball pixels per frame on each axis
- PADDLE_SPEED, 4, paddle pixels per frame
- WIN_SCORE, 7, points needed to win
- SERVE_FRAMES, 60, frames the ball is held centered before play

Ports:
- CLOCK_50  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- frame_tick  in  1  one-cycle pulse at start of vertical blank
- serve  in  1  one-cycle pulse from the synced start key
- p1_up, p1_dn, p2_up, p2_dn  in  1 each  synced, level-sensitive paddle buttons
- ball_x, ball_y  out  10  ball top-left corner
- p1_y, p2_y  out  10  paddle top edges
- score1, score2  out  4  player scores
- state  out  3  IDLE=0, SERVE=1, PLAY=2, POINT=3, OVER=4
- winner  out  2  00 none, 01 player1, 10 player2

Behaviour:
- Reset is asynchronous on reset_n low and returns to the same values mid-game.
  - ball_x=316, ball_y=236; p1_y=p2_y=216; scores 0; state IDLE; winner 00
  - dir_x=1 (right), dir_y=1 (down), serve countdown 0
- All outputs are registered. Updates land on the cycle after the frame_tick that triggers them; no other cycle changes game state except serve.
- IDLE:
  - serve -> SERVE, countdown loaded with SERVE_FRAMES.
  - serve coincident with frame_tick does not decrement the countdown.
- SERVE:
  - Ball held at center.
  - Each frame_tick decrements the countdown and moves paddles.
  - frame_tick while countdown==1 -> PLAY.
- PLAY, per frame_tick:
  - Paddles move first; the ball then tests against the old paddle positions.
  - Paddle move: up-only subtracts PADDLE_SPEED, saturating at 0. Down-only adds PADDLE_SPEED, saturating at V_ACTIVE-PADDLE_H. Both or neither pressed: no move.
  - Ball vertical, moving up: if ball_y<BALL_SPEED, then ball_y=0 and dir_y flips. Otherwise ball_y-=BALL_SPEED.
  - Ball vertical, moving down: if ball_y+BALL_SIZE+BALL_SPEED>V_ACTIVE, then ball_y=V_ACTIVE-BALL_SIZE and dir_y flips. Otherwise ball_y+=BALL_SPEED.
  - Vertical overlap with a paddle: ball_y+BALL_SIZE>p_y and ball_y<p_y+PADDLE_H.
  - Left paddle hit: moving left, ball_x>=PADDLE_X1+8, ball_x-BALL_SPEED<PADDLE_X1+8, and overlap with p1 -> ball_x=PADDLE_X1+8, dir_x=1.
  - Right paddle hit: mirrored; ball_x+BALL_SIZE<=PADDLE_X2 and the next position crosses PADDLE_X2 -> ball_x=PADDLE_X2-BALL_SIZE, dir_x=0.
  - Left miss: moving left and ball_x<BALL_SPEED -> POINT, scorer = player2.
  - Right miss: moving right and ball_x+BALL_SIZE+BALL_SPEED>H_ACTIVE -> POINT, scorer = player1.
  - All arithmetic is 11-bit internally to avoid wrap. No output ever leaves the visible area.
- POINT lasts exactly one cycle (not frame-gated):
  - Scorer's score increments.
  - If the new score == WIN_SCORE: -> OVER, winner set.
  - Otherwise: -> SERVE with the ball recentered, dir_x pointing toward the conceding player, dir_y=1, countdown reloaded.
- OVER:
  - Positions frozen.
  - serve clears scores and winner, recenters ball and paddles -> SERVE.
- serve is ignored in SERVE, PLAY and POINT.

Optional Feature:
- PONG_AI_EN defined:
  - Player 2 is automatic and p2_up/p2_dn are ignored.
  - Each frame in SERVE/PLAY, p2_y moves PADDLE_SPEED toward the ball using the same saturation rules.
  - Paddle center is p2_y+PADDLE_H/2; ball center is ball_y+BALL_SIZE/2.
  - Up if paddle center > ball center+4; down if paddle center < ball center-4; else hold.
- PONG_AI_EN undefined: p2 is driven by buttons exactly as p1.

Test Plan:
- Reset low mid-PLAY -> same cycle: state=0, ball (316,236), paddles 216, scores 0.
- serve in IDLE, then 60 frame_ticks -> state=1 for 59 ticks, state=2 after tick 60, ball still (316,236).
- PLAY with p1_up held for 60 frames from p1_y=216 -> p1_y=0 after 54 frames, then stays 0. Both buttons held -> no motion.
- Ball moving left at ball_x=25, p1_y=216, ball_y=236 -> next frame ball_x=24 with dir_x right. Same case with p1_y=0 -> ball continues; POINT when ball_x<2; score2=1; state SERVE with dir_x left.
- Ball moving down at ball_y=471 -> ball_y=472, dir_y up, next frame 470.
- score1=6 and a right-edge miss -> score1=7, state=4, winner=01. serve -> scores 0, state=1.
